btb_write_scheduler: RTL and testbench
======================================

BTB_WRITE_SCHEDULER -- requirements
Module: btb_write_scheduler

Interface
REQ-001 SHALL have parameter WRITE_NUM, default 2, number of request and write ports.
REQ-002 SHALL have parameter ENTRY_NUM, default 1024, BTB entries; INDEX_BITS = log2(ENTRY_NUM).
REQ-003 SHALL have parameter BANK_NUM, default 2, BTB banks; bank = index[log2(BANK_NUM)-1:0].
REQ-004 SHALL have parameter ENTRY_BIT_SIZE, default 32, width of one BTB entry payload.
REQ-005 SHALL have parameter QUEUE_SIZE, default 4, conflict queue depth (power of two).
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port flushReq  in  1  one-cycle pulse that restarts the invalidation sweep.
REQ-009 SHALL have port reqValid  in  WRITE_NUM  per-port write request valid (from IntEx branch results).
REQ-010 SHALL have port reqIndex  in  WRITE_NUM x INDEX_BITS  requested entry index.
REQ-011 SHALL have port reqData  in  WRITE_NUM x ENTRY_BIT_SIZE  requested entry payload.
REQ-012 SHALL have port we  out  WRITE_NUM  registered write enable to the BTB array.
REQ-013 SHALL have port wa  out  WRITE_NUM x INDEX_BITS  registered write address.
REQ-014 SHALL have port wv  out  WRITE_NUM x ENTRY_BIT_SIZE  registered write payload.
REQ-015 SHALL have port initBusy  out  1  high while the invalidation sweep runs.
REQ-016 SHALL have port queueCount  out  log2(QUEUE_SIZE)+1  current conflict-queue occupancy.
REQ-017 SHALL have port dropCount  out  16  saturating count of discarded requests.

Function
REQ-018 SHALL implement FSM states INIT and RUN; reset enters INIT.
REQ-019 SHALL, in INIT, issue we[0]=1, wa[0]=sweep index, wv[0]=0 each cycle, we[others]=0, sweep index 0..ENTRY_NUM-1 then go to RUN; initBusy=1 exactly ENTRY_NUM cycles.
REQ-020 SHALL, in INIT, ignore reqValid entirely (no grant, no queue push, no dropCount change).
REQ-021 SHALL, on flushReq in RUN, empty the queue and enter INIT with sweep index 0 next cycle; flushReq in INIT restarts sweep at 0.
REQ-022 SHALL, in RUN, grant requests in ascending port order; request i is granted directly unless its bank equals that of a granted lower-indexed request.
REQ-023 SHALL push the lowest-indexed non-granted request into the queue; further non-granted requests that cycle are dropped.
REQ-024 SHALL drop the push candidate when queue is full and no pop occurs that cycle; simultaneous push and pop when full SHALL succeed.
REQ-025 SHALL pop at most one queue head per cycle into the lowest-indexed idle port, only if its bank conflicts with no direct grant; otherwise head waits.
REQ-026 SHALL give direct requests priority over the queue head for ports and banks.
REQ-027 SHALL register all grants: request accepted at cycle N appears on we/wa/wv at N+1; queued entry pushed at N writes no earlier than N+2.
REQ-028 SHALL add the number of dropped requests per cycle to dropCount, saturating at 16'hFFFF.
REQ-029 SHALL never assert two we bits with equal bank in the same cycle.
REQ-030 SHALL wrap queue head/tail pointers modulo QUEUE_SIZE; queueCount SHALL range 0..QUEUE_SIZE.

Reset
REQ-031 SHALL, on rst, asynchronously set state=INIT, sweep index=0, queue pointers and count=0, dropCount=0, we=0, wa=0, wv=0, initBusy=1.
REQ-032 SHALL, on rst asserted mid-sweep or mid-drain, discard all queued entries and restart the sweep at 0 after release.

Structure
REQ-033 SHALL place the FSM state enum, queue entry struct {index, data} and bank-extract function in the shared FetchUnitTypes package.
REQ-034 SHALL instantiate one sub-module, btb_conflict_queue (FIFO with push/pop/full/empty/count), built on the existing QueuePointer.

Verification (WRITE_NUM=2, BANK_NUM=2, QUEUE_SIZE=4, ENTRY_NUM=16)
REQ-035 SHALL check reset release -> 16 cycles we=2'b01, wa[0]=0..15, wv[0]=0, initBusy=1, then initBusy=0.
REQ-036 SHALL check RUN, reqIndex={5,2} valid both -> next cycle we=2'b11, wa={5,2}, queueCount=0.
REQ-037 SHALL check reqIndex={4,6} valid -> we=2'b01 wa[0]=6 at N+1; queued 4 written on port 1 at N+2 if no conflicting direct request; queueCount 1 then 0.
REQ-038 SHALL check five consecutive cycles of {2,4} with queue undrained -> queueCount saturates at 4, dropCount=1.
REQ-039 SHALL check flushReq with queueCount=3 -> queueCount=0 next cycle, 16-cycle sweep from index 0, no queued entry ever written.

Source files
------------

// File: rtl/btb_write_scheduler_pkg.sv
// Shared fetch-unit types: scheduler FSM states, conflict-queue entry layout, BTB bank extraction.
`default_nettype none

package FetchUnitTypes;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } btb_sched_state_t;

  localparam int BTB_DEFAULT_INDEX_BITS = 10;
  localparam int BTB_DEFAULT_ENTRY_BITS = 32;

  // Entry layout for the default geometry; parameterised users declare the same shape locally.
  typedef struct packed {
    logic [BTB_DEFAULT_INDEX_BITS-1:0] index;
    logic [BTB_DEFAULT_ENTRY_BITS-1:0] data;
  } btb_queue_entry_t;

  function automatic logic [31:0] btb_bank(input logic [31:0] index, input int bank_bits);
    return index & ((32'd1 << bank_bits) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/QueuePointer.sv
// Wrapping ring-buffer pointer for power-of-two queues.
`default_nettype none

module QueuePointer #(
  parameter int SIZE = 4,
  localparam int PTR_BITS = $clog2(SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                advance,
  output logic [PTR_BITS-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (clear)   ptr <= '0;
    else if (advance) ptr <= ptr + PTR_BITS'(1);
  end

endmodule

`default_nettype wire

// File: rtl/btb_write_scheduler_conflict_queue.sv
// FIFO holding BTB writes that lost a bank conflict; a push while full succeeds only alongside a pop.
`default_nettype none

module btb_conflict_queue #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic,
  localparam int PTR_BITS = $clog2(DEPTH),
  localparam int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  entry_t              push_data,
  output entry_t              pop_data,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);

  entry_t               mem [DEPTH];
  logic [PTR_BITS-1:0]  head;
  logic [PTR_BITS-1:0]  tail;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == CNT_BITS'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && (!full || do_pop) && !flush;
  assign pop_data = mem[head];

  QueuePointer #(.SIZE(DEPTH)) u_head (
    .clk(clk), .rst(rst), .clear(flush), .advance(do_pop), .ptr(head)
  );

  QueuePointer #(.SIZE(DEPTH)) u_tail (
    .clk(clk), .rst(rst), .clear(flush), .advance(do_push), .ptr(tail)
  );

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    count <= '0;
    else if (flush)             count <= '0;
    else if (do_push && !do_pop) count <= count + CNT_BITS'(1);
    else if (do_pop && !do_push) count <= count - CNT_BITS'(1);
  end

endmodule

`default_nettype wire

// File: rtl/btb_write_scheduler.sv
// Schedules per-port BTB write requests onto banked write ports, queueing one bank loser per cycle,
// and sweeps every entry to zero after reset or flush.
`default_nettype none

module btb_write_scheduler
  import FetchUnitTypes::*;
#(
  parameter int WRITE_NUM      = 2,
  parameter int ENTRY_NUM      = 1024,
  parameter int BANK_NUM       = 2,
  parameter int ENTRY_BIT_SIZE = 32,
  parameter int QUEUE_SIZE     = 4,
  localparam int INDEX_BITS = $clog2(ENTRY_NUM),
  localparam int QCNT_BITS  = $clog2(QUEUE_SIZE) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     flushReq,
  input  logic [WRITE_NUM-1:0]                     reqValid,
  input  logic [WRITE_NUM-1:0][INDEX_BITS-1:0]     reqIndex,
  input  logic [WRITE_NUM-1:0][ENTRY_BIT_SIZE-1:0] reqData,
  output logic [WRITE_NUM-1:0]                     we,
  output logic [WRITE_NUM-1:0][INDEX_BITS-1:0]     wa,
  output logic [WRITE_NUM-1:0][ENTRY_BIT_SIZE-1:0] wv,
  output logic                                     initBusy,
  output logic [QCNT_BITS-1:0]                     queueCount,
  output logic [15:0]                              dropCount
);

  localparam int BANK_BITS = $clog2(BANK_NUM);
  localparam int PORT_BITS = (WRITE_NUM > 1) ? $clog2(WRITE_NUM) : 1;
  localparam int DROP_BITS = $clog2(WRITE_NUM + 1);

  typedef struct packed {
    logic [INDEX_BITS-1:0]     index;
    logic [ENTRY_BIT_SIZE-1:0] data;
  } entry_t;

  btb_sched_state_t state, state_next;
  logic [INDEX_BITS-1:0] sweep;
  logic                  sweep_last;
  logic                  active;

  logic [WRITE_NUM-1:0]  grant;
  logic                  conflict, push_req, pop, port_found, head_conflict;
  logic [PORT_BITS-1:0]  cand, pop_port;
  logic [DROP_BITS-1:0]  drop_n;
  logic [16:0]           drop_sum;
  entry_t                push_entry, q_head;
  logic                  q_full, q_empty;

  logic [WRITE_NUM-1:0]                     we_n;
  logic [WRITE_NUM-1:0][INDEX_BITS-1:0]     wa_n;
  logic [WRITE_NUM-1:0][ENTRY_BIT_SIZE-1:0] wv_n;

  assign sweep_last = (sweep == INDEX_BITS'(ENTRY_NUM - 1));
  // A flush cycle in RUN does no scheduling work; it only tears down the queue.
  assign active     = (state == RUN) && !flushReq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= state_next;
      if (state == INIT && !flushReq && !sweep_last) sweep <= sweep + INDEX_BITS'(1);
      else                                            sweep <= '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (!flushReq && sweep_last) state_next = RUN;
      RUN:     if (flushReq) state_next = INIT;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    grant    = '0;
    push_req = 1'b0;
    cand     = '0;
    drop_n   = '0;
    conflict = 1'b0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      conflict = 1'b0;
      for (int j = 0; j < WRITE_NUM; j++) begin
        if (j < i && grant[j] &&
            btb_bank(32'(reqIndex[j]), BANK_BITS) == btb_bank(32'(reqIndex[i]), BANK_BITS))
          conflict = 1'b1;
      end
      if (active && reqValid[i]) begin
        if (!conflict) begin
          grant[i] = 1'b1;
        end else if (!push_req) begin
          push_req = 1'b1;
          cand     = PORT_BITS'(i);
        end else begin
          drop_n = drop_n + DROP_BITS'(1);
        end
      end
    end

    // The queue head only takes a port and bank that no direct grant wants.
    port_found    = 1'b0;
    pop_port      = '0;
    head_conflict = 1'b0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      if (grant[i] &&
          btb_bank(32'(reqIndex[i]), BANK_BITS) == btb_bank(32'(q_head.index), BANK_BITS))
        head_conflict = 1'b1;
      if (!grant[i] && !port_found) begin
        port_found = 1'b1;
        pop_port   = PORT_BITS'(i);
      end
    end
    pop = active && !q_empty && port_found && !head_conflict;
    if (push_req && q_full && !pop) drop_n = drop_n + DROP_BITS'(1);

    we_n = '0;
    wa_n = wa;
    wv_n = wv;
    if (state == INIT) begin
      we_n[0] = 1'b1;
      wa_n[0] = sweep;
      wv_n[0] = '0;
    end else begin
      for (int i = 0; i < WRITE_NUM; i++) begin
        if (grant[i]) begin
          we_n[i] = 1'b1;
          wa_n[i] = reqIndex[i];
          wv_n[i] = reqData[i];
        end else if (pop && pop_port == PORT_BITS'(i)) begin
          we_n[i] = 1'b1;
          wa_n[i] = q_head.index;
          wv_n[i] = q_head.data;
        end
      end
    end
  end

  assign push_entry = '{index: reqIndex[cand], data: reqData[cand]};
  assign drop_sum   = {1'b0, dropCount} + 17'(drop_n);

  btb_conflict_queue #(.DEPTH(QUEUE_SIZE), .entry_t(entry_t)) u_queue (
    .clk(clk), .rst(rst), .flush(flushReq),
    .push(push_req), .pop(pop),
    .push_data(push_entry), .pop_data(q_head),
    .full(q_full), .empty(q_empty), .count(queueCount)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we        <= '0;
      wa        <= '0;
      wv        <= '0;
      initBusy  <= 1'b1;
      dropCount <= '0;
    end else begin
      we        <= we_n;
      wa        <= wa_n;
      wv        <= wv_n;
      initBusy  <= (state == INIT);
      dropCount <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btb_write_scheduler.sv
// Randomised bench for btb_write_scheduler with a queue-based reference model and directed anchors.
`default_nettype none

module tb_btb_write_scheduler;

  localparam int WN = 2;
  localparam int EN = 16;
  localparam int BN = 2;
  localparam int EB = 32;
  localparam int QS = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flushReq;
  logic [WN-1:0]          reqValid;
  logic [WN-1:0][3:0]     reqIndex;
  logic [WN-1:0][EB-1:0]  reqData;
  logic [WN-1:0]          we;
  logic [WN-1:0][3:0]     wa;
  logic [WN-1:0][EB-1:0]  wv;
  logic                   initBusy;
  logic [2:0]             queueCount;
  logic [15:0]            dropCount;

  int n_checks = 0;
  int n_fail   = 0;

  btb_write_scheduler #(
    .WRITE_NUM(WN), .ENTRY_NUM(EN), .BANK_NUM(BN), .ENTRY_BIT_SIZE(EB), .QUEUE_SIZE(QS)
  ) dut (
    .clk(clk), .rst(rst), .flushReq(flushReq),
    .reqValid(reqValid), .reqIndex(reqIndex), .reqData(reqData),
    .we(we), .wa(wa), .wv(wv),
    .initBusy(initBusy), .queueCount(queueCount), .dropCount(dropCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state describes the outputs visible after the most recent clock edge.
  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } ment_t;

  ment_t       mq[$];
  bit          m_init;
  int          m_sweep;
  int          m_drops;
  logic [1:0]  e_we;
  logic [3:0]  e_wa[WN];
  logic [31:0] e_wv[WN];
  bit          e_busy;

  task automatic m_reset();
    mq.delete();
    m_init  = 1'b1;
    m_sweep = 0;
    m_drops = 0;
    e_we    = '0;
    e_busy  = 1'b1;
  endtask

  task automatic m_step();
    bit bank_used[BN];
    bit granted[WN];
    int rej[$];
    int port;
    int b;
    e_we = '0;
    if (m_init) begin
      e_we     = 2'b01;
      e_wa[0]  = 4'(m_sweep);
      e_wv[0]  = '0;
      e_busy   = 1'b1;
      if (flushReq)            m_sweep = 0;
      else if (m_sweep == EN-1) begin m_sweep = 0; m_init = 1'b0; end
      else                     m_sweep++;
    end else begin
      e_busy = 1'b0;
      if (flushReq) begin
        mq.delete();
        m_init  = 1'b1;
        m_sweep = 0;
      end else begin
        for (int i = 0; i < BN; i++) bank_used[i] = 1'b0;
        for (int i = 0; i < WN; i++) begin
          granted[i] = 1'b0;
          if (reqValid[i]) begin
            b = int'(reqIndex[i]) % BN;
            if (!bank_used[b]) begin
              bank_used[b] = 1'b1;
              granted[i]   = 1'b1;
              e_we[i]      = 1'b1;
              e_wa[i]      = reqIndex[i];
              e_wv[i]      = reqData[i];
            end else begin
              rej.push_back(i);
            end
          end
        end
        if (mq.size() > 0) begin
          port = -1;
          for (int i = 0; i < WN; i++) if (!granted[i] && port < 0) port = i;
          if (port >= 0 && !bank_used[int'(mq[0].idx) % BN]) begin
            e_we[port] = 1'b1;
            e_wa[port] = mq[0].idx;
            e_wv[port] = mq[0].data;
            void'(mq.pop_front());
          end
        end
        if (rej.size() > 0) begin
          if (mq.size() < QS) mq.push_back('{reqIndex[rej[0]], reqData[rej[0]]});
          else                m_drops++;
          m_drops += rej.size() - 1;
          if (m_drops > 65535) m_drops = 65535;
        end
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (rst) m_reset();
      chk("we", 32'(we), 32'(e_we));
      chk("initBusy", 32'(initBusy), 32'(e_busy));
      chk("queueCount", 32'(queueCount), mq.size());
      chk("dropCount", 32'(dropCount), m_drops);
      for (int i = 0; i < WN; i++) begin
        if (e_we[i]) begin
          chk("wa", 32'(wa[i]), 32'(e_wa[i]));
          chk("wv", wv[i], e_wv[i]);
        end
      end
      if (rst) m_reset();
      else     m_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input int i1, input int i0);
    reqValid    = v;
    reqIndex[1] = 4'(i1);
    reqIndex[0] = 4'(i0);
    reqData[1]  = 32'hD100_0000 | 32'(i1);
    reqData[0]  = 32'hD000_0000 | 32'(i0);
  endtask

  task automatic drive_random();
    for (int i = 0; i < WN; i++) begin
      reqValid[i] = ($urandom_range(0, 9) < 6);
      reqIndex[i] = 4'($urandom_range(0, EN - 1));
      reqData[i]  = $urandom;
    end
  endtask

  initial begin
    rst      = 1'b1;
    flushReq = 1'b0;
    drive(2'b00, 0, 0);
    repeat (3) step();
    chk("reset_we", 32'(we), 0);
    chk("reset_busy", 32'(initBusy), 1);
    chk("reset_qcount", 32'(queueCount), 0);
    chk("reset_drop", 32'(dropCount), 0);
    #2 rst = 1'b0;

    // Sweep after reset; requests offered during the sweep must be ignored.
    for (int k = 0; k < EN; k++) begin
      if (k < EN - 1) drive_random();
      else            drive(2'b00, 0, 0);
      step();
      chk("sweep_we", 32'(we), 1);
      chk("sweep_wa", 32'(wa[0]), k);
      chk("sweep_busy", 32'(initBusy), 1);
    end
    drive(2'b00, 0, 0);
    step();
    chk("run_busy", 32'(initBusy), 0);
    chk("run_drop", 32'(dropCount), 0);

    // Different banks: both granted directly.
    drive(2'b11, 5, 2);
    step();
    chk("dual_we", 32'(we), 3);
    chk("dual_wa1", 32'(wa[1]), 5);
    chk("dual_wa0", 32'(wa[0]), 2);
    chk("dual_wv1", wv[1], 32'hD100_0005);
    chk("dual_qcount", 32'(queueCount), 0);

    // Same bank: port 1 queued, then drained to port 1 beside a bank-1 direct write.
    drive(2'b11, 4, 6);
    step();
    chk("conf_we", 32'(we), 1);
    chk("conf_wa0", 32'(wa[0]), 6);
    chk("conf_qcount", 32'(queueCount), 1);
    drive(2'b01, 0, 1);
    step();
    chk("drain_we", 32'(we), 3);
    chk("drain_wa1", 32'(wa[1]), 4);
    chk("drain_wv1", wv[1], 32'hD100_0004);
    chk("drain_qcount", 32'(queueCount), 0);

    // Five conflicting cycles: queue fills, fifth loser is dropped.
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 2, 4);
      step();
      chk("fill_qcount", 32'(queueCount), (k < 4) ? k + 1 : 4);
    end
    chk("fill_drop", 32'(dropCount), 1);
    drive(2'b00, 0, 0);
    step();
    chk("pop_qcount", 32'(queueCount), 3);

    // Flush with three queued entries: queue emptied, fresh sweep, nothing queued ever written.
    flushReq = 1'b1;
    step();
    flushReq = 1'b0;
    chk("flush_qcount", 32'(queueCount), 0);
    chk("flush_we", 32'(we), 0);
    for (int k = 0; k < EN; k++) begin
      step();
      chk("resweep_wa", 32'(wa[0]), k);
      chk("resweep_busy", 32'(initBusy), 1);
    end
    step();
    chk("resweep_done", 32'(initBusy), 0);
    repeat (3) begin
      step();
      chk("flush_idle_we", 32'(we), 0);
    end

    for (int n = 0; n < 1500; n++) begin
      drive_random();
      flushReq = ($urandom_range(0, 79) == 0);
      step();
      if (n == 700 || $urandom_range(0, 399) == 0) begin
        #2 rst = 1'b1;
        step();
        step();
        #2 rst = 1'b0;
      end
    end
    flushReq = 1'b0;
    drive(2'b00, 0, 0);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
